// File: rtl/tdd_frame_sched.sv
// TDD frame scheduler: tick counter, SOF pulse, one-shot length adjust, TX/RX windows; outputs registered, 1 clk after tick.
// Optional TDD_FRAME_NUM_EN adds a 32-bit frame_num output counting frames after the first SOF.
module tdd_frame_sched #(
    parameter int CW      = 24,
    parameter int MIN_LEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          tddmode,
    input  logic          tick,
    input  logic [CW-1:0] frame_len,
    input  logic [CW-1:0] frame_adj,
    input  logic          adj_wr,
    input  logic [CW-1:0] tstart,
    input  logic [CW-1:0] tend,
    input  logic [CW-1:0] rstart,
    input  logic [CW-1:0] rend,
    output logic [CW-1:0] frame_cnt,
    output logic          frame_sof,
    output logic          tx_win,
    output logic          rx_win,
`ifdef TDD_FRAME_NUM_EN
    output logic [31:0]   frame_num,
`endif
    output logic          adj_pending
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [CW+1:0] MINV = (CW+2)'(MIN_LEN);
    localparam logic [CW+1:0] MAXV = {2'b00, {CW{1'b1}}};

    state_t        r_state, w_nstate;
    logic [CW-1:0] r_cnt, w_ncnt;
    logic [CW-1:0] r_cur_len, w_ncur;
    logic [CW-1:0] r_adj_val;
    logic          r_sof, r_tx, r_rx, r_pend;
    logic          w_bnd, w_ntx, w_nrx;
    logic [CW+1:0] w_sum;
    logic [CW-1:0] w_eff;

    function automatic logic in_win(input logic [CW-1:0] c, input logic [CW-1:0] s,
                                    input logic [CW-1:0] e);
        if (s <= e) return (c >= s) && (c <= e);
        else        return (c >= s) || (c <= e);
    endfunction

    // Signed sum in CW+2 bits so both underflow and overflow saturate instead of wrapping.
    always_comb begin
        w_sum = {2'b00, frame_len} + {{2{r_adj_val[CW-1]}}, r_adj_val};
        if (r_pend) begin
            if ($signed(w_sum) < $signed(MINV))      w_eff = MINV[CW-1:0];
            else if ($signed(w_sum) > $signed(MAXV)) w_eff = MAXV[CW-1:0];
            else                                     w_eff = w_sum[CW-1:0];
        end else begin
            w_eff = (frame_len < CW'(MIN_LEN)) ? CW'(MIN_LEN) : frame_len;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_bnd    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ncnt = '0;
                if (run) w_nstate = ARM;
            end
            ARM: begin
                if (tick) begin
                    w_bnd    = 1'b1;
                    w_ncnt   = '0;
                    w_nstate = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (r_cnt == r_cur_len - CW'(1)) begin
                        w_bnd  = 1'b1;
                        w_ncnt = '0;
                    end else begin
                        w_ncnt = r_cnt + CW'(1);
                    end
                end
            end
            default: w_nstate = IDLE;
        endcase
        if (!run) begin
            w_nstate = IDLE;
            w_ncnt   = '0;
            w_bnd    = 1'b0;
        end
        w_ncur = w_bnd ? w_eff : r_cur_len;
        w_ntx  = 1'b0;
        w_nrx  = 1'b0;
        if (w_nstate == ARM) begin
            w_ntx = !tddmode;
            w_nrx = !tddmode;
        end else if (w_nstate == RUN) begin
            w_ntx = tddmode ? in_win(w_ncnt, tstart, tend) : 1'b1;
            w_nrx = tddmode ? in_win(w_ncnt, rstart, rend) : 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cur_len <= CW'(MIN_LEN);
            r_adj_val <= '0;
            r_sof     <= 1'b0;
            r_tx      <= 1'b0;
            r_rx      <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_cnt     <= w_ncnt;
            r_cur_len <= w_ncur;
            r_sof     <= w_bnd;
            r_tx      <= w_ntx;
            r_rx      <= w_nrx;
            // A write coincident with a boundary survives to the next boundary.
            if (adj_wr) begin
                r_adj_val <= frame_adj;
                r_pend    <= 1'b1;
            end else if (w_bnd) begin
                r_pend    <= 1'b0;
            end
        end
    end

`ifdef TDD_FRAME_NUM_EN
    logic [31:0] r_frame_num;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_frame_num <= '0;
        else if (w_nstate == IDLE)        r_frame_num <= '0;
        else if (w_bnd && r_state == RUN) r_frame_num <= r_frame_num + 32'd1;
    end
    assign frame_num = r_frame_num;
`endif

    assign frame_cnt   = r_cnt;
    assign frame_sof   = r_sof;
    assign tx_win      = r_tx;
    assign rx_win      = r_rx;
    assign adj_pending = r_pend;

endmodule

// File: doc/tdd_frame_sched.md
Name: tdd_frame_sched

Overview:
- Frame-timing scheduler for the AXI-stream sample path.
- Counts sample ticks within a radio frame of programmable length.
- Applies one-shot frame-length adjustments at frame boundaries.
- Generates the TX/RX window enables that gate the oen/ien datapaths in TDD mode. It is driven by the AXI2S control registers: frame_len, frame_adj, tstart/tend, rstart/rend and tddmode. It returns adj_pending to the status register.

Parameters:
- CW, 24, width of frame counter and all timing fields.
- MIN_LEN, 2, minimum effective frame length in ticks.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- run  input  1  scheduler enable (ien|oen); low holds the scheduler idle
- tddmode  input  1  1 = windowed TDD, 0 = both windows follow run
- tick  input  1  one sample-period strobe, at most one per clk
- frame_len  input  CW  nominal frame length in ticks
- frame_adj  input  CW  signed two's-complement length delta for one frame
- adj_wr  input  1  one-clk pulse when FRAME_ADJ is written
- tstart, tend  input  CW  TX window bounds, inclusive
- rstart, rend  input  CW  RX window bounds, inclusive
- frame_cnt  output  CW  current tick index within frame
- frame_sof  output  1  one-clk pulse on the tick that makes frame_cnt 0
- tx_win  output  1  TX window enable
- rx_win  output  1  RX window enable
- adj_pending  output  1  adjustment latched, not yet applied

Behaviour:
- Reset: frame_cnt=0, frame_sof=0, tx_win=0, rx_win=0, adj_pending=0, internal adj_val=0, cur_len=MIN_LEN, state=IDLE.
- State IDLE:
  - Outputs as reset, except adj_pending, which retains its value.
  - On run=1, go to ARM.
- State ARM:
  - On the first tick: frame_cnt←0, frame_sof=1, cur_len←eff_len, go to RUN.
- State RUN, on each tick:
  - If frame_cnt==cur_len-1: frame_cnt←0, frame_sof=1, cur_len←eff_len.
  - Otherwise frame_cnt←frame_cnt+1.
  - No tick: all state holds.
  - run=0 in any state: go to IDLE next clk; the counter clears.
- eff_len:
  - Base value is frame_len, clamped up to MIN_LEN.
  - If adj_pending=1, eff_len = clamp(frame_len + sign-extended adj_val, MIN_LEN, 2^CW-1). Compute in CW+2 bits and saturate; no wrap.
  - Using a pending adjustment at a boundary clears adj_pending in the same clk.
- Adjustment handshake:
  - adj_wr latches adj_val←frame_adj and sets adj_pending=1.
  - adj_wr while already pending overwrites adj_val; pending stays 1; only the last value is applied.
  - adj_wr in the same clk as a boundary tick: the boundary uses nominal length (or the previously pending value, if one was pending). The new value stays pending for the next boundary.
- frame_len changes mid-frame take effect only at the next boundary, because cur_len is captured at SOF.
- Windows:
  - Computed from the next-state frame_cnt and registered, so tx_win/rx_win align with frame_cnt. Latency: tick at clk n → updated frame_cnt/windows visible at n+1.
  - TX in-window, case tstart<=tend: tstart<=cnt<=tend.
  - TX in-window, case tstart>tend (wrap across boundary): cnt>=tstart or cnt<=tend.
  - RX uses rstart/rend with the same rules.
  - tddmode=0: tx_win=rx_win=1 in ARM and RUN.
  - tddmode=1: tx_win/rx_win = in-window in RUN; 0 in ARM.
  - Window bounds >= cur_len never match that part of the range; no error is raised.
- frame_sof is a single-clk pulse, registered with frame_cnt.

Optional Feature:
- Macro TDD_FRAME_NUM_EN.
- When defined: adds output frame_num [31:0], reset 0.
  - Increments, wrapping 2^32-1→0, on every frame_sof except the first after ARM.
  - Cleared on entry to IDLE.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-RUN with frame_cnt=37 and adj_pending=1 → all outputs 0 in the same cycle as rst, asynchronously; cur_len=2 after release.
- frame_len=10, tddmode=1, tstart=2, tend=4, rstart=6, rend=9, tick every clk → frame_cnt 0..9 repeating; tx_win high at cnt 2–4; rx_win at 6–9; frame_sof at cnt 0 only.
- Wrap window: tstart=8, tend=1, frame_len=10 → tx_win high at cnt 8, 9, 0, 1.
- Adjustment handshake:
  - frame_adj=0xFFFFFD (-3), adj_wr mid-frame → adj_pending=1; next frame is 7 ticks, then reverts to 10; adj_pending clears at that SOF.
  - adj_wr coincident with the boundary tick → that frame is 10 ticks, the following frame is 7.
- Clamps and idle entry:
  - frame_len=1 → period 2.
  - frame_len=5 with frame_adj=-10 → period 2.
  - run dropped mid-frame → IDLE next clk, windows 0, adj_pending retained.
- With TDD_FRAME_NUM_EN: 3 complete frames after ARM → frame_num=3; a run toggle clears it to 0.
